ir_cmd_scheduler: RTL and testbench

//  Sits between the IR frame decoder and the application logic. Captures each decoded frame
//  (command byte plus inverted check byte) and validates it. Tracks button-hold via repeat

---
 rtl/ir_ctrl_pkg.sv | 13 +
 rtl/ir_cmd_fifo.sv | 46 ++++
 rtl/ir_cmd_scheduler.sv | 110 +++++++++++
 tb/tb_ir_cmd_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ir_ctrl_pkg.sv
// ir_ctrl_pkg: shared types and constants for the IR command scheduler.
package ir_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic       rpt;
    } ir_entry_t;

    localparam logic [7:0] CHK_XOR = 8'hFF;

endpackage

// File: rtl/ir_cmd_fifo.sv
// ir_cmd_fifo: synchronous FIFO of IR command entries with push/pop and full/empty flags.
module ir_cmd_fifo
    import ir_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  ir_entry_t din,
    input  logic      pop,
    output ir_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    ir_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// ir_cmd_scheduler: validates decoded IR frames, tracks button hold, queues commands.
// Define IR_CMD_AUTOREPEAT_EN to queue a repeat entry for every repeat code seen in HOLD.
module ir_cmd_scheduler
    import ir_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLD_TO = 1000000,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frm_valid,
    input  logic [7:0]       frm_cmd,
    input  logic [7:0]       frm_chk,
    input  logic             frm_rpt,
    output logic             dec_clear,
    output logic             cmd_valid,
    output logic [7:0]       cmd_data,
    output logic             cmd_rpt,
    input  logic             cmd_ready,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             hold_act
);

    localparam int TW = $clog2(HOLD_TO);

    state_t        state, state_nx;
    logic [7:0]    cmd_l, chk_l;
    logic [TW-1:0] timer;
    logic          chk_ok, push, pop, err_inc, drop, full, empty;
    ir_entry_t     push_e, head;
`ifdef IR_CMD_AUTOREPEAT_EN
    logic [7:0]    last_cmd;
`endif

    assign chk_ok    = chk_l == (cmd_l ^ CHK_XOR);
    assign dec_clear = state == CHECK;
    assign hold_act  = state == HOLD;
    assign cmd_valid = !empty;
    assign cmd_data  = head.cmd;
    assign cmd_rpt   = head.rpt;
    assign pop       = cmd_valid && cmd_ready;
    assign drop      = push && full && !pop;

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        push_e   = '{cmd: cmd_l, rpt: 1'b0};
        err_inc  = 1'b0;
        case (state)
            IDLE:  if (frm_valid) state_nx = CHECK;
            CHECK: begin
                push     = chk_ok;
                err_inc  = !chk_ok;
                state_nx = chk_ok ? HOLD : IDLE;
            end
            HOLD: begin
                if (frm_valid) state_nx = CHECK;
                else if (!frm_rpt && timer == TW'(HOLD_TO - 1)) state_nx = IDLE;
`ifdef IR_CMD_AUTOREPEAT_EN
                if (frm_rpt && !frm_valid) begin
                    push   = 1'b1;
                    push_e = '{cmd: last_cmd, rpt: 1'b1};
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cmd_l    <= '0;
            chk_l    <= '0;
            timer    <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
`ifdef IR_CMD_AUTOREPEAT_EN
            last_cmd <= '0;
`endif
        end else begin
            state <= state_nx;
            if (frm_valid && state != CHECK) begin
                cmd_l <= frm_cmd;
                chk_l <= frm_chk;
            end
            if (state == CHECK || (state == HOLD && frm_rpt)) timer <= '0;
            else if (state == HOLD) timer <= timer + TW'(1);
`ifdef IR_CMD_AUTOREPEAT_EN
            if (state == CHECK && chk_ok) last_cmd <= cmd_l;
`endif
            if (err_inc && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    ir_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_e),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// tb_ir_cmd_scheduler: directed checks of frame validation, FIFO, hold timeout and reset.
module tb_ir_cmd_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frm_valid, frm_rpt, cmd_ready;
    logic [7:0] frm_cmd, frm_chk;
    logic       dec_clear, cmd_valid, cmd_rpt, hold_act;
    logic [7:0] cmd_data, err_cnt, drop_cnt, b;
    int         passes = 0, total = 0;

    ir_cmd_scheduler #(.DEPTH(4), .HOLD_TO(100), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .frm_valid (frm_valid),
        .frm_cmd   (frm_cmd),
        .frm_chk   (frm_chk),
        .frm_rpt   (frm_rpt),
        .dec_clear (dec_clear),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_rpt   (cmd_rpt),
        .cmd_ready (cmd_ready),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt),
        .hold_act  (hold_act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in CHECK (the frame has been captured on the last edge).
    task automatic send(input logic [7:0] c, input logic [7:0] k);
        frm_cmd   = c;
        frm_chk   = k;
        frm_valid = 1'b1;
        tick();
        frm_valid = 1'b0;
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; frm_valid = 1'b0; frm_rpt = 1'b0; cmd_ready = 1'b0;
        frm_cmd = '0; frm_chk = '0;
        tick(); tick();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_hold_act", hold_act, 0);
        chk("rst_dec_clear", dec_clear, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        reset_n = 1'b1;
        tick();

        // 1: good frame
        send(8'h45, 8'hBA);
        chk("t1_dec_clear", dec_clear, 1);
        chk("t1_not_yet_valid", cmd_valid, 0);
        tick();
        chk("t1_cmd_valid", cmd_valid, 1);
        chk("t1_cmd_data", cmd_data, 8'h45);
        chk("t1_cmd_rpt", cmd_rpt, 0);
        chk("t1_hold_act", hold_act, 1);
        chk("t1_dec_clear_off", dec_clear, 0);
        pop_one();
        chk("t1_popped", cmd_valid, 0);

        // 2: bad check byte from HOLD
        send(8'h45, 8'hBB);
        chk("t2_dec_clear", dec_clear, 1);
        tick();
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_no_push", cmd_valid, 0);
        chk("t2_hold_act", hold_act, 0);

        // 3: overflow and in-order drain
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send(b, ~b);
            tick();
        end
        chk("t3_drop_cnt", drop_cnt, 1);
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain_valid", cmd_valid, 1);
            chk("t3_drain_data", cmd_data, i);
            tick();
        end
        cmd_ready = 1'b0;
        chk("t3_empty", cmd_valid, 0);

        // 4: repeats spaced 60 cycles keep the hold alive
        send(8'h16, 8'hE9);
        tick();
        for (int k = 0; k < 3; k++) begin
            repeat (60) tick();
            frm_rpt = 1'b1;
            tick();
            frm_rpt = 1'b0;
        end
        chk("t4_hold_act", hold_act, 1);
        chk("t4_head_valid", cmd_valid, 1);
        chk("t4_head_data", cmd_data, 8'h16);
        chk("t4_head_rpt", cmd_rpt, 0);
        pop_one();
`ifdef IR_CMD_AUTOREPEAT_EN
        for (int k = 0; k < 3; k++) begin
            chk("t4_rpt_valid", cmd_valid, 1);
            chk("t4_rpt_data", cmd_data, 8'h16);
            chk("t4_rpt_flag", cmd_rpt, 1);
            pop_one();
        end
`endif
        chk("t4_drained", cmd_valid, 0);

        // 5: hold timeout after HOLD_TO cycles, late repeat ignored
        send(8'h22, 8'hDD);
        tick();
        pop_one();
        repeat (98) tick();
        chk("t5_hold_before_to", hold_act, 1);
        tick();
        chk("t5_hold_after_to", hold_act, 0);
        frm_rpt = 1'b1;
        tick();
        frm_rpt = 1'b0;
        tick();
        chk("t5_rpt_ignored", cmd_valid, 0);
        chk("t5_still_idle", hold_act, 0);

        // 6: async reset mid-HOLD with 2 entries
        send(8'h31, 8'hCE);
        tick();
        send(8'h32, 8'hCD);
        tick();
        chk("t6_pre_valid", cmd_valid, 1);
        chk("t6_pre_hold", hold_act, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", cmd_valid, 0);
        chk("t6_rst_hold", hold_act, 0);
        chk("t6_rst_err", err_cnt, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        tick();
        reset_n = 1'b1;
        tick();
        send(8'h5A, 8'hA5);
        tick();
        chk("t6_post_valid", cmd_valid, 1);
        chk("t6_post_data", cmd_data, 8'h5A);
        chk("t6_post_hold", hold_act, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
